// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: host push bus plus UART load port of the transmit byte queue.
// The slave modport is the queue itself. The master modport is the environment
// that drives it, which is the host together with the UART transmitter.
interface uart_tx_queue_if #(
    parameter int AW = 4
);
    logic          wr_req;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          clr_overflow;
    logic          ld_tx_req;
    logic          ld_tx_ack;
    logic [7:0]    tx_data;
    logic          tx_empty;

    modport master (
        output wr_req, wr_data, clr_overflow, ld_tx_ack, tx_empty,
        input  full, empty, count, overflow, ld_tx_req, tx_data
    );

    modport slave (
        input  wr_req, wr_data, clr_overflow, ld_tx_ack, tx_empty,
        output full, empty, count, overflow, ld_tx_req, tx_data
    );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus the four-phase load sequencer for a UART transmitter.
// A load starts only while the transmitter reports idle, so the UART never overruns.
// Optional build macro UART_TXQ_SYNC_EN adds a 2-flop synchroniser on ld_tx_ack and
// tx_empty. Use it when the UART runs on a clock other than clk.
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_tx_queue_if.slave bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt;
    logic          full_r;
    logic          empty_r;
    logic          overflow_r;
    logic [7:0]    tx_data_r;
    logic          ld_req_r;
    logic          ack_s;
    logic          tx_empty_s;
    logic          push;
    logic          pop;

`ifdef UART_TXQ_SYNC_EN
    logic [1:0] ack_sync;
    logic [1:0] txe_sync;

    // Two-flop synchronisers. tx_empty resets to 1 because the UART is idle out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_sync <= 2'b00;
            txe_sync <= 2'b11;
        end else begin
            ack_sync <= {ack_sync[0], bus.ld_tx_ack};
            txe_sync <= {txe_sync[0], bus.tx_empty};
        end
    end

    assign ack_s      = ack_sync[1];
    assign tx_empty_s = txe_sync[1];
`else
    assign ack_s      = bus.ld_tx_ack;
    assign tx_empty_s = bus.tx_empty;
`endif

    // A push while full is dropped. Fullness is taken from the registered flag,
    // so a pop in the same cycle does not make room for the push.
    assign push = bus.wr_req && !full_r;

    // Next-state logic of the load handshake. A pop happens only on REQ -> DROP.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (!empty_r && tx_empty_s && !ack_s) state_nxt = REQ;
            REQ: begin
                if (ack_s) begin
                    pop       = 1'b1;
                    state_nxt = DROP;
                end
            end
            DROP: if (!ack_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_nxt = count_r;
        case ({push, pop})
            2'b10:   count_nxt = count_r + (AW+1)'(1);
            2'b01:   count_nxt = count_r - (AW+1)'(1);
            default: count_nxt = count_r;
        endcase
    end

    // State, pointers, flags and the registered load request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            ld_req_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ld_req_r <= (state_nxt == REQ);
            count_r  <= count_nxt;
            full_r   <= (count_nxt == DEPTH_C);
            empty_r  <= (count_nxt == '0);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            // A same-cycle overflow takes priority over the clear.
            if (bus.wr_req && full_r)  overflow_r <= 1'b1;
            else if (bus.clr_overflow) overflow_r <= 1'b0;
        end
    end

    // Byte storage. The data path is not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    // The head byte is sampled only in IDLE, so it stays frozen through REQ and DROP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    tx_data_r <= 8'h00;
        else if (state == IDLE && !empty_r) tx_data_r <= mem[rd_ptr];
    end

    assign bus.full      = full_r;
    assign bus.empty     = empty_r;
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;
    assign bus.ld_tx_req = ld_req_r;
    assign bus.tx_data   = tx_data_r;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: random-data bench for uart_tx_queue with a behavioural UART load model.
// The reference tracks queue contents and occupancy from the observable push strobes
// and load completions. The same bench works with or without UART_TXQ_SYNC_EN.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.AW(AW)) bus();

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: bytes accepted but not yet loaded, occupancy, sticky overflow.
    logic [7:0] exp_q[$];
    int   ref_cnt = 0;
    logic ref_ovf = 1'b0;
    int   acc_cnt = 0;
    logic wr_prev = 1'b0, clr_prev = 1'b0, req_prev = 1'b0;
    logic [7:0] wd_prev = 8'h00;

    // UART model state.
    logic uart_ack = 1'b0;
    int   uart_busy = 0;
    logic [7:0] cap_byte = 8'h00;
    int   loads = 0;
    logic hold = 1'b0;
    logic ack_block = 1'b0;

    assign bus.ld_tx_ack = uart_ack;
    assign bus.tx_empty  = (uart_busy == 0) && !hold;

    // UART transmitter load port. It acks a request, releases ack when req drops,
    // and goes busy on the release edge for a random time.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uart_ack  <= 1'b0;
            uart_busy <= 0;
        end else if (!uart_ack && bus.ld_tx_req && !ack_block) begin
            check("overrun", 32'(uart_busy), 32'd0);
            if (exp_q.size() == 0) check("spurious_load", 32'(bus.tx_data), 32'hFFFF);
            else                   check("load_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            cap_byte <= bus.tx_data;
            loads    <= loads + 1;
            uart_ack <= 1'b1;
        end else if (uart_ack && !bus.ld_tx_req) begin
            uart_ack  <= 1'b0;
            uart_busy <= int'($urandom_range(1, 6));
        end else begin
            if (uart_ack && bus.ld_tx_req) check("tx_data_stable", 32'(bus.tx_data), 32'(cap_byte));
            if (uart_busy != 0) uart_busy <= uart_busy - 1;
        end
    end

    // Mid-cycle reference update and flag comparison.
    // A push is accepted when the queue held fewer than DEPTH bytes before the edge.
    // A falling ld_tx_req marks the pop.
    always @(negedge clk) begin
        if (!reset_n) begin
            ref_cnt = 0;
            ref_ovf = 1'b0;
            exp_q.delete();
        end else begin
            if (wr_prev && ref_cnt == DEPTH) ref_ovf = 1'b1;
            else if (clr_prev)               ref_ovf = 1'b0;
            if (wr_prev && ref_cnt < DEPTH) begin
                exp_q.push_back(wd_prev);
                acc_cnt++;
                ref_cnt++;
            end
            if (req_prev && !bus.ld_tx_req) ref_cnt--;
        end
        check("count", 32'(bus.count), 32'(ref_cnt));
        check("full", 32'(bus.full), 32'(ref_cnt == DEPTH));
        check("empty", 32'(bus.empty), 32'(ref_cnt == 0));
        check("overflow", 32'(bus.overflow), 32'(ref_ovf));
        wr_prev  = reset_n && bus.wr_req;
        wd_prev  = bus.wr_data;
        clr_prev = reset_n && bus.clr_overflow;
        req_prev = reset_n && bus.ld_tx_req;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr_req  = 1'b1;
        bus.wr_data = b;
        cyc(1);
        bus.wr_req  = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_overflow = 1'b1;
        cyc(1);
        bus.clr_overflow = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!bus.ld_tx_req && n < budget) begin
            cyc(1);
            n++;
        end
        check("req_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.ld_tx_req || uart_ack || uart_busy != 0 ||
                bus.count != 0) && n < budget) begin
            cyc(1);
            n++;
        end
        check("idle_timeout", 32'(n < budget), 32'd1);
        cyc(4);
    endtask

    initial begin
        int l0;
        int a0;
        int n;
        bus.wr_req       = 1'b0;
        bus.wr_data      = 8'h00;
        bus.clr_overflow = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_req", 32'(bus.ld_tx_req), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);

        // T1: single byte
        l0 = loads;
        push(8'h41);
        wait_req(20);
        check("t1_tx_data", 32'(bus.tx_data), 32'h41);
        check("t1_count1", 32'(bus.count), 32'd1);
        wait_idle(200);
        check("t1_count0", 32'(bus.count), 32'd0);
        check("t1_empty", 32'(bus.empty), 32'd1);
        check("t1_loads", 32'(loads - l0), 32'd1);

        // T2: three back-to-back bytes, paced by tx_empty
        l0 = loads;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_idle(500);
        check("t2_loads", 32'(loads - l0), 32'd3);

        // T3: fill past DEPTH while the UART is busy
        l0 = loads;
        hold = 1'b1;
        cyc(4);
        for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
        check("t3_full", 32'(bus.full), 32'd1);
        check("t3_count", 32'(bus.count), 32'd16);
        check("t3_overflow", 32'(bus.overflow), 32'd1);
        pulse_clr();
        check("t3_clr", 32'(bus.overflow), 32'd0);
        hold = 1'b0;
        wait_idle(3000);
        check("t3_loads", 32'(loads - l0), 32'd16);

        // T4: push against a full queue on the same edge as the pop
        l0 = loads;
        ack_block = 1'b1;
        cyc(2);
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        check("t4_full", 32'(bus.full), 32'd1);
        check("t4_req_held", 32'(bus.ld_tx_req), 32'd1);
        pulse_clr();
        bus.wr_req  = 1'b1;
        bus.wr_data = 8'hEE;
        ack_block   = 1'b0;
        n = 0;
        while (bus.ld_tx_req && n < 50) begin
            cyc(1);
            n++;
        end
        bus.wr_req = 1'b0;
        check("t4_pop_timeout", 32'(n < 50), 32'd1);
        check("t4_count", 32'(bus.count), 32'd15);
        check("t4_overflow", 32'(bus.overflow), 32'd1);
        pulse_clr();
        wait_idle(3000);
        check("t4_loads", 32'(loads - l0), 32'd16);

        // T5: bursts past the pointer wrap, some while the UART drains
        l0 = loads;
        a0 = acc_cnt;
        for (int r = 0; r < 3; r++) begin
            hold = 1'b1;
            cyc(4);
            for (int i = 0; i < int'($urandom_range(5, 12)); i++) push(8'($urandom));
            hold = 1'b0;
            wait_idle(2000);
        end
        for (int i = 0; i < 20; i++) push(8'($urandom));
        wait_idle(3000);
        check("t5_loads", 32'(loads - l0), 32'(acc_cnt - a0));

        // T6: reset while a request is outstanding
        l0 = loads;
        ack_block = 1'b1;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        cyc(20);
        check("t6_req_held", 32'(bus.ld_tx_req), 32'd1);
        check("t6_count3", 32'(bus.count), 32'd3);
        reset_n = 1'b0;
        #1;
        check("t6_req_async", 32'(bus.ld_tx_req), 32'd0);
        cyc(3);
        reset_n   = 1'b1;
        ack_block = 1'b0;
        cyc(10);
        check("t6_req", 32'(bus.ld_tx_req), 32'd0);
        check("t6_empty", 32'(bus.empty), 32'd1);
        check("t6_count0", 32'(bus.count), 32'd0);
        check("t6_loads", 32'(loads - l0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
